// File: rtl/dyn_brnch_pred_gshare_param.sv
// Correlating branch predictor: global history register plus a table of saturating
// counters, indexed either by history alone (GAg) or by history XOR branch address (gshare).
module dyn_brnch_pred_gshare_param #(
    parameter int GHR_W      = 5,
    parameter int IDX_W      = 5,
    parameter int CTR_W      = 2,
    parameter int INDEX_MODE = 1,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              brch_instr_detectd_IF,
    input  logic [IDX_W-1:0]  branch_addr_IF,
    input  logic              brch_instr_detectd_ID,
    input  logic              brch_hazard_stall,
    input  logic              actual_brch_result,
    input  logic              flush_ID,
    output logic              predict_br_taken,
    output logic              mispredict_ID,
    output logic [STAT_W-1:0] mispredict_cnt
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

    function automatic logic [CTR_W-1:0] ctr_sat_step(input logic [CTR_W-1:0] c,
                                                      input logic up);
        logic [CTR_W-1:0] r;
        r = c;
        if (up && (c != '1))
            r = c + CTR_W'(1);
        else if (!up && (c != '0))
            r = c - CTR_W'(1);
        return r;
    endfunction

    function automatic logic [STAT_W-1:0] stat_sat_inc(input logic [STAT_W-1:0] s);
        return (s == '1) ? s : s + STAT_W'(1);
    endfunction

    logic [GHR_W-1:0] ghr;
    logic [GHR_W-1:0] ghr_nxt;
    logic [CTR_W-1:0] pht [DEPTH];
    logic [IDX_W-1:0] hist;
    logic [IDX_W-1:0] idx_p0;
    logic             pred_p0;
    logic             vld_p1;
    logic [IDX_W-1:0] idx_p1;
    logic             pred_p1;
    logic             upd;

    generate
        if (GHR_W >= IDX_W) begin : g_hist_trunc
            assign hist = ghr[IDX_W-1:0];
        end else begin : g_hist_ext
            assign hist = {{(IDX_W - GHR_W){1'b0}}, ghr};
        end

        if (GHR_W == 1) begin : g_ghr_one
            assign ghr_nxt = actual_brch_result;
        end else begin : g_ghr_shift
            assign ghr_nxt = {ghr[GHR_W-2:0], actual_brch_result};
        end
    endgenerate

    // IF stage: lookup reads the pre-update table and history (no bypass)
    assign idx_p0           = (INDEX_MODE != 0) ? (hist ^ branch_addr_IF) : hist;
    assign pred_p0          = pht[idx_p0][CTR_W-1];
    assign predict_br_taken = pred_p0 & brch_instr_detectd_IF;

    // ID stage: resolve against the carried index/prediction
    assign upd = brch_instr_detectd_ID & vld_p1 & ~brch_hazard_stall & ~flush_ID;
    assign mispredict_ID = upd & (pred_p1 != actual_brch_result);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr            <= '0;
            vld_p1         <= 1'b0;
            idx_p1         <= '0;
            pred_p1        <= 1'b0;
            mispredict_cnt <= '0;
            for (int i = 0; i < DEPTH; i++)
                pht[i] <= CTR_INIT;
        end else begin
            // A flush squashes whatever IF would have handed to ID this edge
            if (!brch_hazard_stall) begin
                vld_p1 <= brch_instr_detectd_IF & ~flush_ID;
                if (brch_instr_detectd_IF) begin
                    idx_p1  <= idx_p0;
                    pred_p1 <= pred_p0;
                end
            end
            if (upd) begin
                pht[idx_p1] <= ctr_sat_step(pht[idx_p1], actual_brch_result);
                ghr         <= ghr_nxt;
            end
            if (mispredict_ID)
                mispredict_cnt <= stat_sat_inc(mispredict_cnt);
        end
    end

endmodule

// File: tb/tb_dyn_brnch_pred_gshare_param.sv
// Directed bench for the gshare/GAg predictor: two configurations share one stimulus
// stream and are scored against a per-configuration reference model.
module tb_dyn_brnch_pred_gshare_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        det_if = 1'b0;
    logic [4:0]  addr = '0;
    logic        det_id = 1'b0;
    logic        stall = 1'b0;
    logic        actual = 1'b0;
    logic        flush = 1'b0;
    logic        pred_a, misp_a, pred_b, misp_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    dyn_brnch_pred_gshare_param dut_a (
        .clk(clk), .rst_n(rst_n), .brch_instr_detectd_IF(det_if), .branch_addr_IF(addr),
        .brch_instr_detectd_ID(det_id), .brch_hazard_stall(stall),
        .actual_brch_result(actual), .flush_ID(flush), .predict_br_taken(pred_a),
        .mispredict_ID(misp_a), .mispredict_cnt(cnt_a)
    );

    dyn_brnch_pred_gshare_param #(
        .GHR_W(1), .IDX_W(5), .CTR_W(2), .INDEX_MODE(0), .STAT_W(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .brch_instr_detectd_IF(det_if), .branch_addr_IF(addr),
        .brch_instr_detectd_ID(det_id), .brch_hazard_stall(stall),
        .actual_brch_result(actual), .flush_ID(flush), .predict_br_taken(pred_b),
        .mispredict_ID(misp_b), .mispredict_cnt(cnt_b)
    );

    typedef struct {
        string       tag;
        int          inst;
        logic        pred;
        logic        misp;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic last_pred_a;

    // reference model, index 0 = dut_a (GHR_W=5, gshare, STAT_W=16), 1 = dut_b (GHR_W=1, GAg, STAT_W=2)
    int ghr_m[2];
    int pht_m[2][32];
    bit vld_m[2];
    int idx_m[2];
    bit pred_m[2];
    int cnt_m[2];

    function automatic int gw(int i);
        return (i == 0) ? 5 : 1;
    endfunction

    function automatic int stat_max(int i);
        return (i == 0) ? 65535 : 3;
    endfunction

    function automatic int idx_if_m(int i, int a);
        return (i == 0) ? ((ghr_m[i] & 31) ^ (a & 31)) : (ghr_m[i] & 31);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ghr_m[i] = 0; vld_m[i] = 0; idx_m[i] = 0; pred_m[i] = 0; cnt_m[i] = 0;
            for (int k = 0; k < 32; k++) pht_m[i][k] = 1;
        end
    endtask

    task automatic model_edge(input bit dif, input int a, input bit did, input bit st,
                              input bit act, input bit fl);
        int ix;
        bit pf;
        bit upd;
        for (int i = 0; i < 2; i++) begin
            ix  = idx_if_m(i, a);
            pf  = (pht_m[i][ix] >= 2);
            upd = did && vld_m[i] && !st && !fl;
            if (upd) begin
                if (act && pht_m[i][idx_m[i]] < 3) pht_m[i][idx_m[i]]++;
                if (!act && pht_m[i][idx_m[i]] > 0) pht_m[i][idx_m[i]]--;
                if (pred_m[i] != act && cnt_m[i] < stat_max(i)) cnt_m[i]++;
                ghr_m[i] = ((ghr_m[i] << 1) | int'(act)) & ((1 << gw(i)) - 1);
            end
            if (!st) begin
                vld_m[i] = dif && !fl;
                if (dif) begin
                    idx_m[i]  = ix;
                    pred_m[i] = pf;
                end
            end
        end
    endtask

    task automatic step(input string tag, input bit dif, input int a, input bit did,
                        input bit st, input bit act, input bit fl);
        exp_t e;
        int   ix;
        det_if = dif; addr = a[4:0]; det_id = did; stall = st; actual = act; flush = fl;
        for (int i = 0; i < 2; i++) begin
            ix     = idx_if_m(i, a);
            e.tag  = tag;
            e.inst = i;
            e.pred = dif && (pht_m[i][ix] >= 2);
            e.misp = did && vld_m[i] && !st && !fl && (pred_m[i] != act);
            e.cnt  = 16'(cnt_m[i]);
            sb.push_back(e);
        end
        #1;
        last_pred_a = pred_a;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 0) begin
                chk({e.tag, "/a_pred"}, 32'(pred_a), 32'(e.pred));
                chk({e.tag, "/a_misp"}, 32'(misp_a), 32'(e.misp));
                chk({e.tag, "/a_cnt"},  32'(cnt_a),  32'(e.cnt));
            end else begin
                chk({e.tag, "/b_pred"}, 32'(pred_b), 32'(e.pred));
                chk({e.tag, "/b_misp"}, 32'(misp_b), 32'(e.misp));
                chk({e.tag, "/b_cnt"},  32'(cnt_b),  32'(e.cnt));
            end
        end
        @(posedge clk);
        model_edge(dif, a, did, st, act, fl);
        @(negedge clk);
    endtask

    task automatic checkpoint(input string tag);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("%s/a_pht%0d", tag, k), 32'(dut_a.pht[k]), 32'(pht_m[0][k]));
            chk($sformatf("%s/b_pht%0d", tag, k), 32'(dut_b.pht[k]), 32'(pht_m[1][k]));
        end
        chk({tag, "/a_ghr"}, 32'(dut_a.ghr), 32'(ghr_m[0]));
        chk({tag, "/b_ghr"}, 32'(dut_b.ghr), 32'(ghr_m[1]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset/a_pred", 32'(pred_a), 32'd0);
        chk("reset/a_misp", 32'(misp_a), 32'd0);
        chk("reset/a_cnt",  32'(cnt_a),  32'd0);
        chk("reset/b_cnt",  32'(cnt_b),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checkpoint("reset");

        step("t1_lookup", 1, 0, 0, 0, 0, 0);
        chk("t1_pred0", 32'(last_pred_a), 32'd0);

        // three taken branches at 0x03 walk idx 03 -> 02 -> 00 under gshare
        for (int n = 0; n < 3; n++) begin
            step("t2_if", 1, 3, 0, 0, 0, 0);
            step("t2_id", 0, 0, 1, 0, 1, 0);
        end
        chk("t2_ghr",   32'(dut_a.ghr),    32'h07);
        chk("t2_pht03", 32'(dut_a.pht[3]), 32'd2);
        chk("t2_pht02", 32'(dut_a.pht[2]), 32'd2);
        chk("t2_pht00", 32'(dut_a.pht[0]), 32'd2);
        chk("t2_cnt",   32'(cnt_a),        32'd3);
        checkpoint("t2");

        for (int n = 0; n < 5; n++) begin
            step("t3_if_t", 1, 10 ^ ghr_m[0], 0, 0, 0, 0);
            step("t3_id_t", 0, 0, 1, 0, 1, 0);
        end
        chk("t3_sat_hi", 32'(dut_a.pht[10]), 32'd3);
        for (int n = 0; n < 5; n++) begin
            step("t3_if_n", 1, 10 ^ ghr_m[0], 0, 0, 0, 0);
            step("t3_id_n", 0, 0, 1, 0, 0, 0);
        end
        chk("t3_sat_lo", 32'(dut_a.pht[10]), 32'd0);
        checkpoint("t3");

        step("t4_cap", 1, 12 ^ ghr_m[0], 0, 0, 0, 0);
        for (int n = 0; n < 3; n++) step("t4_stall", 1, 7, 1, 1, 1, 0);
        checkpoint("t4_hold");
        step("t4_rel", 0, 0, 1, 0, 1, 0);
        chk("t4_pht12", 32'(dut_a.pht[12]), 32'd2);
        checkpoint("t4");

        step("t5_cap", 1, 14 ^ ghr_m[0], 0, 0, 0, 0);
        step("t5_flush", 1, 5, 1, 0, 1, 1);
        step("t5_after", 0, 0, 1, 0, 0, 0);
        chk("t5_pht14", 32'(dut_a.pht[14]), 32'd1);
        checkpoint("t5");

        step("t6_cap", 1, 25 ^ ghr_m[0], 0, 0, 0, 0);
        step("t6_same", 1, 25 ^ ghr_m[0], 1, 0, 1, 0);
        chk("t6_same_pred", 32'(last_pred_a), 32'd0);
        step("t6_next", 1, 25 ^ ghr_m[0], 0, 0, 0, 0);
        chk("t6_next_pred", 32'(last_pred_a), 32'd1);

        // force repeated mispredicts on the 2-bit statistics counter
        for (int n = 0; n < 5; n++) begin
            step("t6_stat_if", 1, 0, 0, 0, 0, 0);
            step("t6_stat_id", 0, 0, 1, 0, !pred_m[1], 0);
        end
        chk("t6_stat_sat", 32'(cnt_b), 32'd3);
        checkpoint("t6");

        step("t7_cap", 1, 9, 0, 0, 0, 0);
        det_if = 1'b1; addr = 5'd9; det_id = 1'b1; actual = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t7_pred",  32'(pred_a),       32'd0);
        chk("t7_misp",  32'(misp_a),       32'd0);
        chk("t7_cnt_a", 32'(cnt_a),        32'd0);
        chk("t7_cnt_b", 32'(cnt_b),        32'd0);
        chk("t7_vld",   32'(dut_a.vld_p1), 32'd0);
        checkpoint("t7");
        @(negedge clk);
        det_if = 1'b0; det_id = 1'b0; actual = 1'b0;
        rst_n = 1'b1;
        step("t8_post", 1, 0, 1, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
